// File: rtl/ysyx_23060124_rst_sequencer_pkg.sv
// Shared definitions for the SoC reset sequencer: FSM state encoding,
// reset-cause codes and a width helper for the domain index register.
package ysyx_23060124_rst_sequencer_pkg;

    // Sequencer states; the encoding is shared with software-visible debug.
    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } rst_state_e;

    // Last reset cause, reported sticky until the next power-on reset.
    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_SW  = 2'b01
    } rst_cause_e;

    // Index width for n domains, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_23060124_stdrst.sv
// Reset release synchroniser: asserts asynchronously, releases on the
// second clock edge after the external reset goes high.
module ysyx_23060124_stdrst (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic [1:0] sync_q;

    // Two-flop shift of a constant 1, cleared the instant i_rst_n drops.
    // NOTE: only the release is synchronised; assertion must stay async so
    // downstream logic is held even when the clock is not running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign o_rst_n = sync_q[1];

endmodule

// File: rtl/ysyx_23060124_rst_sequencer.sv
// SoC reset sequencer: holds all downstream domains in reset for HOLD_CYC
// cycles, then releases them one at a time (index 0 first) every GAP_CYC
// cycles. A level software/watchdog request restarts the whole sequence.
module ysyx_23060124_rst_sequencer
    import ysyx_23060124_rst_sequencer_pkg::*;
#(
    parameter int unsigned N_OUT    = 4,
    parameter int unsigned HOLD_CYC = 16,
    parameter int unsigned GAP_CYC  = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sw_rst_req,
    output logic [N_OUT-1:0] o_rst_n,
    output logic             o_rst_done,
    output logic             o_busy,
    output logic [1:0]       o_rst_cause
);

    localparam int unsigned IDX_W = idx_width(N_OUT);

    // Terminal counts compared on CNT_W bits; HOLD_CYC/GAP_CYC of 2**CNT_W
    // still fit because the compare value is one less.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);

    if (N_OUT < 1 || HOLD_CYC < 1 || GAP_CYC < 1 ||
        HOLD_CYC > (64'd1 << CNT_W) || GAP_CYC > (64'd1 << CNT_W)) begin : g_param_check
        $error("rst_sequencer: N_OUT, HOLD_CYC or GAP_CYC out of range for CNT_W");
    end

    logic             rst_sync_n;
    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_OUT-1:0] rst_n_q, rst_n_d;
    rst_cause_e       cause_q, cause_d;

    ysyx_23060124_stdrst u_stdrst (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_rst_n (rst_sync_n)
    );

    // Next-state logic: request overrides everything, else hold/release walk.
    // NOTE: every target gets its current value first, so no path through
    // this block can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        cause_d = cause_q;

        if (i_sw_rst_req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            cause_d = CAUSE_SW;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        rst_n_d[idx_q] = 1'b1;
                        cnt_d          = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_n_d = '0;
                end
            endcase
        end
    end

    // State, counter, index and registered reset outputs, cleared by the
    // synchronised reset (which itself asserts asynchronously).
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            cause_q <= cause_d;
        end
    end

    assign o_rst_n     = rst_n_q;
    assign o_rst_done  = (state_q == ST_RUN);
    assign o_busy      = (state_q != ST_RUN);
    assign o_rst_cause = cause_q;

endmodule
